// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control unit for the multicycle ARM datapath.
// A 10-entry control store walked by a micro-PC, with opcode dispatch, memory-wait stall and retire counter.
module micro_sequencer #(
  parameter int UPC_W    = 4,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic                Stall,
  output logic                NextPC,
  output logic                Branch,
  output logic                RegW,
  output logic                MemW,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                ALUOp,
  output logic [UPC_W-1:0]    uPC,
  output logic                InstrDone,
  output logic [RETIRE_W-1:0] RetireCount
);

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXECR  = 4'd6;
  localparam logic [3:0] ST_EXECI  = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;

  localparam logic [1:0] SQ_SEQ   = 2'd0;
  localparam logic [1:0] SQ_FETCH = 2'd1;
  localparam logic [1:0] SQ_DISP1 = 2'd2;
  localparam logic [1:0] SQ_DISP2 = 2'd3;

  logic [UPC_W-1:0]    upc_reg;
  logic [UPC_W-1:0]    upc_next;
  logic [RETIRE_W-1:0] retire_reg;
  logic                legal;
  logic                go;
  logic                retire;
  logic [1:0]          seq;
  logic [3:0]          seq_target;
  logic [3:0]          disp_target;
  logic                next_pc_raw;
  logic                branch_raw;
  logic                reg_w_raw;
  logic                mem_w_raw;
  logic                ir_write_raw;
  logic                unused_funct;

  assign unused_funct = ^Funct[4:1];
  assign legal        = (upc_reg < UPC_W'(10));
  assign go           = ~Stall & ~reset;

  // Control store; out-of-range addresses fall through to all-zero with SEQ->0
  always_comb begin
    next_pc_raw  = 1'b0;
    branch_raw   = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    ir_write_raw = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 1'b0;
    seq          = SQ_SEQ;
    seq_target   = ST_FETCH;
    if (legal) begin
      case (upc_reg[3:0])
        ST_FETCH: begin
          ALUSrcA      = 2'b01;
          ALUSrcB      = 2'b10;
          ResultSrc    = 2'b10;
          ir_write_raw = 1'b1;
          next_pc_raw  = 1'b1;
          seq_target   = ST_DECODE;
        end
        ST_DECODE: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          seq       = SQ_DISP1;
        end
        ST_MEMADR: begin
          ALUSrcB = 2'b01;
          seq     = SQ_DISP2;
        end
        ST_MEMRD: begin
          AdrSrc     = 1'b1;
          seq_target = ST_MEMWB;
        end
        ST_MEMWB: begin
          ResultSrc = 2'b01;
          reg_w_raw = 1'b1;
          seq       = SQ_FETCH;
        end
        ST_MEMWR: begin
          AdrSrc    = 1'b1;
          mem_w_raw = 1'b1;
          seq       = SQ_FETCH;
        end
        ST_EXECR: begin
          ALUOp      = 1'b1;
          seq_target = ST_ALUWB;
        end
        ST_EXECI: begin
          ALUSrcB    = 2'b01;
          ALUOp      = 1'b1;
          seq_target = ST_ALUWB;
        end
        ST_ALUWB: begin
          reg_w_raw = 1'b1;
          seq       = SQ_FETCH;
        end
        ST_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ResultSrc  = 2'b10;
          branch_raw = 1'b1;
          seq        = SQ_FETCH;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_target = ST_FETCH;
    case (seq)
      SQ_SEQ:   disp_target = seq_target;
      SQ_FETCH: disp_target = ST_FETCH;
      SQ_DISP1: begin
        case (Op)
          2'b00:   disp_target = Funct[5] ? ST_EXECI : ST_EXECR;
          2'b01:   disp_target = ST_MEMADR;
          2'b10:   disp_target = ST_BRANCH;
          default: disp_target = ST_FETCH;
        endcase
      end
      SQ_DISP2: disp_target = Funct[0] ? ST_MEMRD : ST_MEMWR;
      default:  disp_target = ST_FETCH;
    endcase
  end

  assign upc_next = UPC_W'(disp_target);
  // Only the normal end-of-instruction path retires; the undefined-op bounce uses DISP1
  assign retire   = go & (seq == SQ_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_reg    <= '0;
      retire_reg <= '0;
    end else if (!Stall) begin
      upc_reg <= upc_next;
      if (retire) begin
        retire_reg <= retire_reg + RETIRE_W'(1);
      end
    end
  end

  assign NextPC      = next_pc_raw & go;
  assign Branch      = branch_raw & go;
  assign RegW        = reg_w_raw & go;
  assign MemW        = mem_w_raw & go;
  assign IRWrite     = ir_write_raw & go;
  assign InstrDone   = retire;
  assign uPC         = upc_reg;
  assign RetireCount = retire_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: instruction-level path model checked every cycle, plus directed literal checks.
module tb_micro_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, Stall;
  logic [1:0] Op;
  logic [5:0] Funct;

  logic        NextPC, Branch, RegW, MemW, IRWrite, AdrSrc, ALUOp, InstrDone;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0]  uPC;
  logic [31:0] RetireCount;

  logic        NextPC_4, Branch_4, RegW_4, MemW_4, IRWrite_4, AdrSrc_4, ALUOp_4, InstrDone_4;
  logic [1:0]  ResultSrc_4, ALUSrcA_4, ALUSrcB_4;
  logic [3:0]  uPC_4;
  logic [3:0]  RetireCount_4;

  micro_sequencer #(.UPC_W(4), .RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Stall(Stall),
    .NextPC(NextPC), .Branch(Branch), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .uPC(uPC), .InstrDone(InstrDone), .RetireCount(RetireCount)
  );

  micro_sequencer #(.UPC_W(4), .RETIRE_W(4)) dut4 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Stall(Stall),
    .NextPC(NextPC_4), .Branch(Branch_4), .RegW(RegW_4), .MemW(MemW_4), .IRWrite(IRWrite_4),
    .AdrSrc(AdrSrc_4), .ResultSrc(ResultSrc_4), .ALUSrcA(ALUSrcA_4), .ALUSrcB(ALUSrcB_4),
    .ALUOp(ALUOp_4), .uPC(uPC_4), .InstrDone(InstrDone_4), .RetireCount(RetireCount_4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: remaining micro-steps of the current instruction, derived from the opcode class
  int          m_cur = 0;
  int          m_path[$];
  bit          m_def = 1'b0;
  longint      m_ret = 0;
  bit          m_valid = 1'b0;

  logic [31:0] trace;
  int          tr_cnt, regw_cnt, memw_cnt, br_cnt, done_cnt;

  // {NextPC,Branch,RegW,MemW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp} for each micro-step
  function automatic logic [12:0] exp_ctrl(input int a);
    logic npc = 0, br = 0, rw = 0, mw = 0, irw = 0, adr = 0, aop = 0;
    logic [1:0] res = 0, sa = 0, sb = 0;
    case (a)
      0: begin sa = 2'b01; sb = 2'b10; res = 2'b10; irw = 1; npc = 1; end
      1: begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
      2: begin sb = 2'b01; end
      3: begin adr = 1; end
      4: begin res = 2'b01; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin aop = 1; end
      7: begin sb = 2'b01; aop = 1; end
      8: begin rw = 1; end
      9: begin sa = 2'b10; sb = 2'b01; res = 2'b10; br = 1; end
      default: ;
    endcase
    return {npc, br, rw, mw, irw, adr, res, sa, sb, aop};
  endfunction

  always begin : compare
    logic        go;
    logic        exp_done;
    logic [12:0] e;
    @(negedge clk);
    #2;
    exp_done = 1'b0;
    if (m_valid) begin
      go       = !reset && !Stall;
      exp_done = go && m_def && (m_cur != 0) && (m_path.size() == 0);
      e        = exp_ctrl(m_cur);
      if (!go) e[12:8] = 5'b0;
      chk("upc", 64'(uPC), 64'(m_cur));
      chk("ctrl", 64'({NextPC, Branch, RegW, MemW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}), 64'(e));
      chk("done", 64'(InstrDone), 64'(exp_done));
      chk("retire", 64'(RetireCount), 64'(m_ret) & 64'hFFFF_FFFF);
      chk("upc_w4", 64'(uPC_4), 64'(m_cur));
      chk("done_w4", 64'(InstrDone_4), 64'(exp_done));
      chk("retire_w4", 64'(RetireCount_4), 64'(m_ret) & 64'hF);
      if (go) begin
        trace = {trace[27:0], uPC};
        tr_cnt++;
      end
      regw_cnt += int'(RegW);
      memw_cnt += int'(MemW);
      br_cnt   += int'(Branch);
      done_cnt += int'(InstrDone);
    end
    if (reset) begin
      m_valid = 1'b1;
      m_cur   = 0;
      m_path.delete();
      m_ret   = 0;
    end else if (m_valid && !Stall) begin
      if (exp_done) m_ret++;
      if (m_cur == 0) begin
        m_def = (Op != 2'b11);
        m_path.delete();
        m_path.push_back(1);
        case (Op)
          2'b00: begin m_path.push_back(Funct[5] ? 7 : 6); m_path.push_back(8); end
          2'b01: begin
            m_path.push_back(2);
            if (Funct[0]) begin m_path.push_back(3); m_path.push_back(4); end
            else m_path.push_back(5);
          end
          2'b10: m_path.push_back(9);
          default: ;
        endcase
      end
      if (m_path.size() == 0) m_cur = 0;
      else m_cur = m_path.pop_front();
    end
  end

  // Runs one instruction from FETCH; optionally stalls stall_n cycles at micro-step stall_upc
  task automatic do_instr(input logic [1:0] op, input logic [5:0] fn, input int stall_upc,
                          input int stall_n, input int n, input logic [31:0] exp_trace,
                          input string name);
    int stalled = 0;
    int guard = 0;
    Op = op; Funct = fn; reset = 1'b0;
    trace = '0; tr_cnt = 0; regw_cnt = 0; memw_cnt = 0; br_cnt = 0; done_cnt = 0;
    forever begin
      Stall = (m_cur == stall_upc) && (stalled < stall_n);
      if (Stall) stalled++;
      @(negedge clk);
      guard++;
      if (tr_cnt >= n || guard > 60) break;
    end
    Stall = 1'b0;
    chk({name, "_steps"}, 64'(tr_cnt), 64'(n));
    chk({name, "_trace"}, 64'(trace), 64'(exp_trace));
    $display("[TB] %s op=%0b funct=%06b upc-trace=%0h cycles=%0d", name, op, fn, trace, guard);
  endtask

  initial begin
    int guard;
    reset = 1'b1; Stall = 1'b0; Op = 2'b00; Funct = 6'b0;
    @(negedge clk);
    @(negedge clk);

    do_instr(2'b00, 6'b000000, -1, 0, 4, 32'h0168, "dp_reg");
    chk("dp_regw", 64'(regw_cnt), 1);
    chk("dp_done", 64'(done_cnt), 1);
    chk("dp_retire", 64'(RetireCount), 1);

    do_instr(2'b01, 6'b000001, -1, 0, 5, 32'h01234, "ldr");
    chk("ldr_regw", 64'(regw_cnt), 1);
    chk("ldr_done", 64'(done_cnt), 1);

    do_instr(2'b01, 6'b000000, 5, 3, 4, 32'h0125, "str_stall");
    chk("str_memw", 64'(memw_cnt), 1);
    chk("str_upc", 64'(uPC), 0);
    chk("str_retire", 64'(RetireCount), 3);

    do_instr(2'b10, 6'b000000, -1, 0, 3, 32'h019, "branch");
    chk("b_branch", 64'(br_cnt), 1);

    do_instr(2'b00, 6'b100000, -1, 0, 4, 32'h0178, "dp_imm");
    chk("dpi_regw", 64'(regw_cnt), 1);

    do_instr(2'b11, 6'b000000, -1, 0, 2, 32'h01, "undef");
    chk("undef_done", 64'(done_cnt), 0);
    chk("undef_strobes", 64'(regw_cnt + memw_cnt + br_cnt), 0);
    chk("undef_retire", 64'(RetireCount), 5);

    // Reset lands while an LDR sits at MEMRD
    Op = 2'b01; Funct = 6'b000001; Stall = 1'b0; reset = 1'b0; regw_cnt = 0; guard = 0;
    while (m_cur != 3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_at_memrd", 64'(uPC), 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_upc", 64'(uPC), 0);
    chk("rst_retire", 64'(RetireCount), 0);
    Op = 2'b00; Funct = 6'b0;
    @(negedge clk);
    chk("rst_regw", 64'(regw_cnt), 0);
    $display("[TB] reset_mid_ldr upc-after=%0h regw=%0d", uPC, regw_cnt);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++)
      do_instr(2'b00, 6'b000000, -1, 0, 4, 32'h0168, "wrap_dp");
    chk("wrap_w4", 64'(RetireCount_4), 1);
    chk("wrap_w32", 64'(RetireCount), 17);

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      Stall = ($urandom_range(0, 3) == 0);
      if (m_cur == 0) begin
        Op    = 2'($urandom);
        Funct = 6'($urandom);
      end
      @(negedge clk);
    end
    $display("[TB] random phase retired=%0d", RetireCount);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogrammed replacement for the multicycle ARM main FSM.
- Holds a 10-entry control-store ROM indexed by a micro-PC (uPC). Each entry emits the raw control word to the condition/ALU-decoder logic and the datapath.
- Next uPC comes from the entry's sequencing field: SEQ, FETCH, DISP1 or DISP2.
- Adds a memory-wait stall and an instruction-retire counter.

Parameters:
- UPC_W, 4: uPC width. Must be ≥4.
- RETIRE_W, 32: retire counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20].
- Stall  in  1  memory not ready; hold the current micro-step.
- NextPC  out  1  PC update strobe.
- Branch  out  1  branch strobe, gated downstream by CondEx.
- RegW  out  1  register write strobe, gated downstream by CondEx/NoWrite.
- MemW  out  1  memory write strobe, gated downstream by CondEx.
- IRWrite  out  1  instruction register load.
- AdrSrc  out  1  0 = PC, 1 = ALUResult register.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 Rn, 01 PC, 10 ALUOut.
- ALUSrcB  out  2  00 Rm, 01 ExtImm, 10 constant 4.
- ALUOp  out  1  1 = use Funct decode, 0 = ADD.
- uPC  out  UPC_W  current micro-address (debug).
- InstrDone  out  1  one-cycle pulse on instruction retire.
- RetireCount  out  RETIRE_W  retired-instruction count.

Behaviour:
- Reset:
  - On a clock edge with reset=1: uPC←0 (FETCH), RetireCount←0.
  - While reset=1, all strobes (NextPC, Branch, RegW, MemW, IRWrite, InstrDone) are forced 0.
  - Reset mid-instruction abandons it; no strobe fires in that cycle.
- Outputs are combinational from uPC. Strobes are additionally gated by ~Stall & ~reset.
- Control store. Fields not listed are 0. Sequencing field in brackets.
  - 0 FETCH: AdrSrc0 ALUSrcA01 ALUSrcB10 ResultSrc10 IRWrite NextPC [SEQ→1]
  - 1 DECODE: ALUSrcA01 ALUSrcB10 ResultSrc10 [DISP1]
  - 2 MEMADR: ALUSrcA00 ALUSrcB01 [DISP2]
  - 3 MEMRD: AdrSrc1 ResultSrc00 [SEQ→4]
  - 4 MEMWB: ResultSrc01 RegW [FETCH]
  - 5 MEMWR: AdrSrc1 ResultSrc00 MemW [FETCH]
  - 6 EXECR: ALUSrcA00 ALUSrcB00 ALUOp1 [SEQ→8]
  - 7 EXECI: ALUSrcA00 ALUSrcB01 ALUOp1 [SEQ→8]
  - 8 ALUWB: ResultSrc00 RegW [FETCH]
  - 9 BRANCH: ALUSrcA10 ALUSrcB01 ResultSrc10 Branch [FETCH]
- SEQ→n targets are explicit ROM constants, not uPC+1.
- DISP1 (on Op):
  - 00 → Funct[5] ? 7 : 6
  - 01 → 2
  - 10 → 9
  - 11 → 0 (undefined op; no strobe issued)
- DISP2 (on Funct[0]): 1 → 3, 0 → 5.
- Dispatch samples Op/Funct in the same cycle uPC is at 1 or 2. The IR is stable from cycle 1 onward.
- Stall:
  - Stall=1: uPC holds, RetireCount holds, strobes are 0, mux selects keep their ROM values.
  - When Stall drops, the step executes normally, exactly once.
- Retire:
  - An unstalled, non-reset cycle whose entry's field is FETCH gives InstrDone=1 and RetireCount+1, wrapping modulo 2^RETIRE_W.
  - The DISP1 undefined-op path to 0 does not count as a retire.
- Illegal uPC 10..(2^UPC_W−1): all outputs 0, next uPC=0, no retire.
- Latency in cycles (FETCH to FETCH, no stalls): LDR 5; STR 4; data-processing 4; B 3.

Test Plan:
- reset=1 for 2 cycles, then release with Op=00 Funct=000000 → uPC sequence 0,1,6,8,0. RegW=1 only at uPC 8. InstrDone pulses once. RetireCount=1.
- LDR (Op=01, Funct[0]=1) → uPC 0,1,2,3,4,0. AdrSrc=1 at 3. RegW with ResultSrc=01 at 4. Total 5 cycles.
- STR (Op=01, Funct[0]=0) with Stall=1 for 3 cycles at uPC 5 → MemW=0 during the stall, exactly 1 MemW cycle after release, uPC returns to 0, RetireCount+1.
- Branch (Op=10) → uPC 0,1,9,0. Branch=1 with ALUSrcA=10 at 9. Immediate data-processing (Funct[5]=1) → path 0,1,7,8.
- Op=11 → uPC 0,1,0 with no strobes and RetireCount unchanged. Assert reset at uPC 3 → next uPC 0 and RegW never asserts.
- RETIRE_W=4, 17 data-processing instructions → RetireCount wraps to 1.
